// File: rtl/trig_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trig_generator_pkg
// Purpose : Register-map constants for the write-only, self-clearing
//           trigger register of the chip register block.
// Revision: 1.0 - initial release
// ============================================================================
package trig_generator_pkg;

  // Register bus geometry
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  // Trigger register location
  localparam logic [10:0] TRIG_ADDR = 11'h00C;

  // Write-data bit assignments inside the trigger register
  localparam int I2SI_OVR_BIT = 0;
  localparam int I2SO_UDR_BIT = 1;

endpackage : trig_generator_pkg
`default_nettype wire

// File: rtl/trig_pulse_bit.sv
`default_nettype none
// ============================================================================
// Module  : trig_pulse_bit
// Purpose : One trigger output. Registers (hit & data_bit) so that every
//           qualifying write yields exactly one high cycle on pulse_o.
// Revision: 1.0 - initial release
// ============================================================================
module trig_pulse_bit
  import trig_generator_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic hit_i,
  input  logic data_bit_i,
  output logic pulse_o
);

  logic pulse_d;
  logic pulse_q;

  // Next pulse value: fire only for a decoded write with this bit set
  always_comb begin
    pulse_d = hit_i & data_bit_i;
  end

  // Pulse flop; re-evaluated every edge, so it self-clears with no write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  // Drive straight from the flop so the strobe is glitch-free
  assign pulse_o = pulse_q;

endmodule : trig_pulse_bit
`default_nettype wire

// File: rtl/trig_generator.sv
`default_nettype none
// ============================================================================
// Module  : trig_generator
// Purpose : Decodes bus writes to the trigger register and converts the
//           selected write-data bits into single-cycle registered clear
//           strobes for the I2S FIFO overrun/underrun flags.
// Revision: 1.0 - initial release
// ============================================================================
module trig_generator
#(
  parameter int          ADDR_W       = trig_generator_pkg::ADDR_W,
  parameter int          DATA_W       = trig_generator_pkg::DATA_W,
  parameter logic [10:0] TRIG_ADDR    = trig_generator_pkg::TRIG_ADDR,
  parameter int          I2SI_OVR_BIT = trig_generator_pkg::I2SI_OVR_BIT,
  parameter int          I2SO_UDR_BIT = trig_generator_pkg::I2SO_UDR_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              xfc,
  output logic              trig_i2si_fifo_overrun_clr,
  output logic              trig_i2so_fifo_underrun_clr
);

  import trig_generator_pkg::*;

  logic hit;
  logic unused_wdata;

  // Full-width address compare qualified by the write strobe; no aliasing
  always_comb begin
    hit = xfc & (address == ADDR_W'(TRIG_ADDR));
  end

  // Remaining trigger-register bits are reserved and deliberately ignored
  assign unused_wdata = ^wdata;

  trig_pulse_bit u_i2si_ovr_clr (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit_i      (hit),
    .data_bit_i (wdata[I2SI_OVR_BIT]),
    .pulse_o    (trig_i2si_fifo_overrun_clr)
  );

  trig_pulse_bit u_i2so_udr_clr (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit_i      (hit),
    .data_bit_i (wdata[I2SO_UDR_BIT]),
    .pulse_o    (trig_i2so_fifo_underrun_clr)
  );

endmodule : trig_generator
`default_nettype wire

// File: tb/tb_trig_generator.sv
`default_nettype none
// ============================================================================
// Module  : tb_trig_generator
// Purpose : Self-checking bench for trig_generator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trig_generator;

  logic        clk;
  logic        rst_n;
  logic [10:0] address;
  logic [7:0]  wdata;
  logic        xfc;
  logic        ovr;
  logic        udr;

  int n_cmp = 0;
  int n_err = 0;

  trig_generator dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .address                     (address),
    .wdata                       (wdata),
    .xfc                         (xfc),
    .trig_i2si_fifo_overrun_clr  (ovr),
    .trig_i2so_fifo_underrun_clr (udr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a strobed write to register 0x00C fires {underrun, overrun}
  // from write-data bits 1 and 0; anything else fires nothing.
  function automatic logic [1:0] ref_pulses(input logic x, input logic [10:0] a,
                                            input logic [7:0] d);
    if (!x || a != 11'h00C) return 2'b00;
    return {d[1], d[0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; xfc = 1'b1; address = 11'h00C; wdata = 8'hFF;
    #1;
    n_cmp++;
    if ({udr, ovr} !== 2'b00) begin
      n_err++; $display("FAIL reset_initial got=%b exp=00", {udr, ovr});
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({udr, ovr} !== 2'b00) begin
        n_err++; $display("FAIL reset_hold cyc=%0d got=%b exp=00", i, {udr, ovr});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({udr, ovr} !== 2'b11) begin
      n_err++; $display("FAIL reset_first_edge got=%b exp=11", {udr, ovr});
    end
    xfc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    logic [1:0] exp;
    address = 11'h00C; xfc = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      wdata = 8'(i);
      exp = ref_pulses(xfc, address, wdata);
      @(posedge clk); #1;
      n_cmp++;
      if ({udr, ovr} !== exp) begin
        n_err++; $display("FAIL ramp wdata=%02h got=%b exp=%b", wdata, {udr, ovr}, exp);
      end
    end
    xfc = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({udr, ovr} !== 2'b00) begin
      n_err++; $display("FAIL ramp_xfc_drop got=%b exp=00", {udr, ovr});
    end
  endtask

  task automatic test_addr_miss();
    logic [10:0] miss [3];
    miss[0] = 11'h00D; miss[1] = 11'h40C; miss[2] = 11'h000;
    xfc = 1'b1; wdata = 8'h03;
    for (int i = 0; i < 3; i++) begin
      address = miss[i];
      @(posedge clk); #1;
      n_cmp++;
      if ({udr, ovr} !== 2'b00) begin
        n_err++; $display("FAIL addr_miss addr=%03h got=%b exp=00", address, {udr, ovr});
      end
    end
    xfc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_no_strobe();
    xfc = 1'b0; address = 11'h00C; wdata = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({udr, ovr} !== 2'b00) begin
        n_err++; $display("FAIL no_strobe cyc=%0d got=%b exp=00", i, {udr, ovr});
      end
    end
  endtask

  task automatic test_isolated();
    logic [7:0] vals [3];
    logic [1:0] exp;
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'hFC;
    address = 11'h00C;
    for (int i = 0; i < 3; i++) begin
      xfc = 1'b1; wdata = vals[i];
      exp = ref_pulses(xfc, address, wdata);
      @(posedge clk); #1;
      xfc = 1'b0;
      n_cmp++;
      if ({udr, ovr} !== exp) begin
        n_err++; $display("FAIL isolated_pulse wdata=%02h got=%b exp=%b", vals[i], {udr, ovr}, exp);
      end
      for (int j = 0; j < 2; j++) begin
        @(posedge clk); #1;
        n_cmp++;
        if ({udr, ovr} !== 2'b00) begin
          n_err++; $display("FAIL isolated_after wdata=%02h cyc=%0d got=%b exp=00", vals[i], j, {udr, ovr});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    address = 11'h00C; wdata = 8'h03; xfc = 1'b1;
    @(posedge clk); #1;
    xfc = 1'b0;
    n_cmp++;
    if ({udr, ovr} !== 2'b11) begin
      n_err++; $display("FAIL async_pre got=%b exp=11", {udr, ovr});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({udr, ovr} !== 2'b00) begin
      n_err++; $display("FAIL async_clear got=%b exp=00", {udr, ovr});
    end
    xfc = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({udr, ovr} !== 2'b00) begin
      n_err++; $display("FAIL async_hold got=%b exp=00", {udr, ovr});
    end
    rst_n = 1'b1; wdata = 8'h02;
    @(posedge clk); #1;
    xfc = 1'b0;
    n_cmp++;
    if ({udr, ovr} !== 2'b10) begin
      n_err++; $display("FAIL async_release got=%b exp=10", {udr, ovr});
    end
  endtask

  task automatic test_random();
    logic [1:0] exp;
    for (int i = 0; i < 300; i++) begin
      xfc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    address = 11'h00C;
        2:       address = 11'h00C ^ (11'd1 << $urandom_range(0, 10));
        default: address = 11'($urandom);
      endcase
      wdata = 8'($urandom);
      exp = ref_pulses(xfc, address, wdata);
      @(posedge clk); #1;
      n_cmp++;
      if ({udr, ovr} !== exp) begin
        n_err++; $display("FAIL random i=%0d x=%b a=%03h d=%02h got=%b exp=%b",
                          i, xfc, address, wdata, {udr, ovr}, exp);
      end
    end
    xfc = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_addr_miss();
    test_no_strobe();
    test_isolated();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_trig_generator
`default_nettype wire
